// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: request FIFO and job sequencer feeding the Fibonacci
// core, with timeout-tagged result capture on a valid/ready output.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_n        request N in, req_ready out (FIFO not full)
//   fib_n, fib_rst         core operand and core reset/start pulse
//   fib_out, fib_ready     core result and its outReady level
//   res_valid/res_ready    result handshake
//   res_data/res_n/res_err result value, its N, timeout flag
//   busy                   scheduler not idle or FIFO not empty
module fib_job_scheduler #(
    parameter int N_W     = 5,
    parameter int OUT_W   = 10,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [N_W-1:0]   req_n,
    output logic             req_ready,
    output logic [N_W-1:0]   fib_n,
    output logic             fib_rst,
    input  logic [OUT_W-1:0] fib_out,
    input  logic             fib_ready,
    output logic             res_valid,
    output logic [OUT_W-1:0] res_data,
    output logic [N_W-1:0]   res_n,
    output logic             res_err,
    input  logic             res_ready,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [N_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic hit;
    logic expire;

    // full comes from the registered count only, so a same-cycle pop
    // never makes room for a push.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;

    // The core is held in reset whenever the scheduler is.
    assign fib_rst = rst || (state == S_START);
    assign busy    = (state != S_IDLE) || !empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        hit       = 1'b0;
        expire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_GUARD;
            // outReady may still be high from the previous job here.
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (fib_ready) begin
                    hit       = 1'b1;
                    state_nxt = S_HOLD;
                end else if (cnt == TO_CNT) begin
                    expire    = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fib_n     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_n     <= '0;
            res_err   <= 1'b0;
        end else begin
            if (pop) begin
                fib_n <= mem[rd_ptr];
            end

            if (state == S_START) begin
                cnt <= '0;
            end else if (state == S_WAIT && !hit && !expire) begin
                cnt <= cnt + 1'b1;
            end

            // A ready core wins over a coincident timeout.
            if (hit) begin
                res_valid <= 1'b1;
                res_data  <= fib_out;
                res_n     <= fib_n;
                res_err   <= 1'b0;
            end else if (expire) begin
                res_valid <= 1'b1;
                res_data  <= '0;
                res_n     <= fib_n;
                res_err   <= 1'b1;
            end else if (state == S_HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb_fib_job_scheduler: directed bench for fib_job_scheduler with a
// behavioural core stub (normal, never-ready and stuck-ready modes).
module tb_fib_job_scheduler;

    localparam int N_W     = 5;
    localparam int OUT_W   = 10;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [N_W-1:0]   req_n = '0;
    logic             req_ready;
    logic [N_W-1:0]   fib_n;
    logic             fib_rst;
    logic [OUT_W-1:0] fib_out = '0;
    logic             fib_ready = 1'b0;
    logic             res_valid;
    logic [OUT_W-1:0] res_data;
    logic [N_W-1:0]   res_n;
    logic             res_err;
    logic             res_ready = 1'b1;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_job_scheduler #(
        .N_W(N_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
        .fib_n(fib_n), .fib_rst(fib_rst),
        .fib_out(fib_out), .fib_ready(fib_ready),
        .res_valid(res_valid), .res_data(res_data), .res_n(res_n),
        .res_err(res_err), .res_ready(res_ready),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Core stub: result table, fixed latency after fib_rst releases.
    function automatic logic [OUT_W-1:0] fib_val(input logic [N_W-1:0] n);
        case (n)
            5'd3:    return 10'd3;
            5'd4:    return 10'd11;
            5'd5:    return 10'd53;
            5'd6:    return 10'd309;
            default: return 10'(n * 7);
        endcase
    endfunction

    logic stub_never = 1'b0;
    logic stub_stuck = 1'b0;
    int   stub_lat = 5;
    int   lat = 0;
    logic stub_run = 1'b0;

    always @(posedge clk) begin
        if (fib_rst) begin
            lat      <= 0;
            stub_run <= 1'b1;
            if (!stub_stuck) fib_ready <= 1'b0;
        end else if (stub_run) begin
            lat <= lat + 1;
            if (lat + 1 == stub_lat) begin
                stub_run <= 1'b0;
                if (!stub_never) begin
                    fib_ready <= 1'b1;
                    fib_out   <= fib_val(fib_n);
                end
            end
        end
    end

    typedef struct packed {
        logic [N_W-1:0]   n;
        logic [OUT_W-1:0] d;
        logic             e;
    } res_t;

    res_t rq[$];
    int   pulses = 0;
    logic prev_rst = 1'b1;
    logic prev_frst = 1'b0;
    logic [N_W-1:0] prev_n = '0;

    always @(posedge clk) begin
        if (!rst && res_valid && res_ready)
            rq.push_back({res_n, res_data, res_err});
        if (!rst && fib_rst) pulses++;
        if (!rst && !prev_rst) begin
            chk("mon_single_pulse", 32'(fib_rst && prev_frst), 0);
            chk("mon_fib_n_stable", 32'(fib_rst || fib_n === prev_n), 1);
        end
        prev_rst  = rst;
        prev_frst = fib_rst;
        prev_n    = fib_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int n, input string tag);
        int k = 0;
        while (rq.size() < n && k < 300) begin
            tick();
            k++;
        end
        chk(tag, 32'(rq.size() >= n), 1);
    endtask

    task automatic chk_res(input string tag, input int n, input int d,
                           input int e);
        res_t r = 'x;
        if (rq.size() > 0) r = rq.pop_front();
        chk({tag, "_n"}, 32'(r.n), n);
        chk({tag, "_data"}, 32'(r.d), d);
        chk({tag, "_err"}, 32'(r.e), e);
    endtask

    initial begin
        int k;
        int p;
        int early;

        // Reset
        tick();
        chk("rst_fib_rst", 32'(fib_rst), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_fib_rst_low", 32'(fib_rst), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fib_n", 32'(fib_n), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_n", 32'(res_n), 0);
        chk("rst_res_err", 32'(res_err), 0);

        // Back-to-back jobs 3..6
        p = pulses;
        req_valid = 1'b1;
        req_n = 5'd3;
        tick();
        chk("t1_no_pulse_yet", 32'(fib_rst), 0);
        chk("t1_busy", 32'(busy), 1);
        req_n = 5'd4;
        tick();
        chk("t1_pulse", 32'(fib_rst), 1);
        chk("t1_fib_n", 32'(fib_n), 3);
        req_n = 5'd5;
        tick();
        req_n = 5'd6;
        tick();
        req_valid = 1'b0;
        wait_res(4, "t1_wait");
        chk_res("t1_r3", 3, 3, 0);
        chk_res("t1_r4", 4, 11, 0);
        chk_res("t1_r5", 5, 53, 0);
        chk_res("t1_r6", 6, 309, 0);
        chk("t1_pulses", 32'(pulses - p), 4);

        // Fill the FIFO while job 7 waits
        req_valid = 1'b1;
        req_n = 5'd7;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t2_start", 32'(fib_rst), 1);
        req_valid = 1'b1;
        for (int i = 8; i <= 11; i++) begin
            req_n = 5'(i);
            tick();
        end
        chk("t2_full", 32'(req_ready), 0);
        req_n = 5'd12;
        k = 0;
        do begin
            tick();
            k++;
        end while (!fib_rst && k < 100);
        req_valid = 1'b0;
        chk("t2_pop", 32'(fib_rst), 1);
        chk("t2_fib_n", 32'(fib_n), 8);
        chk("t2_ready_again", 32'(req_ready), 1);
        wait_res(5, "t2_wait");
        chk_res("t2_r7", 7, 49, 0);
        chk_res("t2_r8", 8, 56, 0);
        chk_res("t2_r9", 9, 63, 0);
        chk_res("t2_r10", 10, 70, 0);
        chk_res("t2_r11", 11, 77, 0);
        repeat (30) tick();
        chk("t2_no_extra", 32'(rq.size()), 0);
        chk("t2_idle", 32'(busy), 0);

        // Backpressure on the result port
        res_ready = 1'b0;
        req_valid = 1'b1;
        req_n = 5'd4;
        tick();
        req_n = 5'd5;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!res_valid && k < 100) begin
            tick();
            k++;
        end
        chk("t3_valid", 32'(res_valid), 1);
        chk("t3_data", 32'(res_data), 11);
        chk("t3_n", 32'(res_n), 4);
        chk("t3_err", 32'(res_err), 0);
        p = pulses;
        repeat (20) begin
            tick();
            chk("t3_hold_valid", 32'(res_valid), 1);
            chk("t3_hold_data", 32'(res_data), 11);
            chk("t3_hold_n", 32'(res_n), 4);
            chk("t3_hold_no_rst", 32'(fib_rst), 0);
        end
        chk("t3_no_pulses", 32'(pulses - p), 0);
        res_ready = 1'b1;
        tick();
        chk("t3_released", 32'(res_valid), 0);
        chk("t3_no_early", 32'(fib_rst), 0);
        tick();
        chk("t3_next", 32'(fib_rst), 1);
        chk("t3_next_n", 32'(fib_n), 5);
        wait_res(2, "t3_wait");
        chk_res("t3_r4", 4, 11, 0);
        chk_res("t3_r5", 5, 53, 0);

        // Timeout with a core that never answers
        stub_never = 1'b1;
        req_valid = 1'b1;
        req_n = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t4_start", 32'(fib_rst), 1);
        early = 0;
        repeat (17) begin
            tick();
            if (res_valid) early++;
        end
        chk("t4_early", 32'(early), 0);
        tick();
        chk("t4_valid", 32'(res_valid), 1);
        chk("t4_err", 32'(res_err), 1);
        chk("t4_data", 32'(res_data), 0);
        chk("t4_n", 32'(res_n), 9);
        wait_res(1, "t4_wait");
        chk_res("t4_r9", 9, 0, 1);
        stub_never = 1'b0;
        req_valid = 1'b1;
        req_n = 5'd5;
        tick();
        req_valid = 1'b0;
        wait_res(1, "t4_wait_next");
        chk_res("t4_r5", 5, 53, 0);

        // Stale outReady from the previous job must be masked
        stub_stuck = 1'b1;
        stub_lat = 1;
        req_valid = 1'b1;
        req_n = 5'd6;
        tick();
        req_valid = 1'b0;
        wait_res(1, "t5_wait");
        chk_res("t5_r6", 6, 309, 0);
        repeat (3) tick();
        stub_stuck = 1'b0;
        stub_lat = 5;

        // Reset mid-job with two requests queued
        req_valid = 1'b1;
        req_n = 5'd3;
        tick();
        req_n = 5'd4;
        tick();
        req_n = 5'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t6_busy", 32'(busy), 1);
        p = pulses;
        rst = 1'b1;
        #1;
        chk("t6_rst_pulse", 32'(fib_rst), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_res_valid", 32'(res_valid), 0);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_req_ready", 32'(req_ready), 1);
        chk("t6_fib_rst", 32'(fib_rst), 0);
        repeat (30) tick();
        chk("t6_no_results", 32'(rq.size()), 0);
        chk("t6_no_pulses", 32'(pulses - p), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Upstream feeder and result collector for the Fibonacci core (fibTopLevel).
- Buffers incoming N requests in a small FIFO and issues them to the core one at a time: drives the core's N input, pulses the core's reset/start input, then waits for outReady.
- Captures the core's result, tagged with its N and a timeout flag, and presents it on a valid/ready output port.
- Lets a host stream many jobs without hand-pulsing the core's rst.

Parameters:
- N_W, 5, width of the request operand N.
- OUT_W, 10, width of the core result.
- DEPTH, 4, request FIFO depth; power of two, at least 2.
- CNT_W, 12, width of the timeout cycle counter.
- TIMEOUT, 4095, number of cycles in WAIT before a job is aborted; must be less than 2^CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request N is present.
- req_n  in  N_W  requested N.
- req_ready  out  1  FIFO can accept a request; equals not-full.
- fib_n  out  N_W  N driven to the core; registered and held stable for the whole job.
- fib_rst  out  1  core reset/start pulse.
- fib_out  in  OUT_W  core result.
- fib_ready  in  1  core outReady, a level signal held until the next fib_rst.
- res_valid  out  1  result available.
- res_data  out  OUT_W  captured fib_out; 0 when timed out.
- res_n  out  N_W  N this result belongs to.
- res_err  out  1  job hit TIMEOUT.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE, or the FIFO is not empty.

Behaviour:
- Reset, synchronous, active-high:
  - FIFO pointers and count cleared; state set to IDLE.
  - fib_n, res_data, res_n, res_err, res_valid, and the timeout counter all go to 0.
  - fib_rst = rst OR (state==START), so the core is held in reset whenever the scheduler is.
  - Reset mid-job discards the job and all queued requests; no result is emitted for them.
- FIFO:
  - Push when req_valid && req_ready. req_ready = !full, where full is computed from the registered count.
  - When full, a push is rejected even if a pop happens in the same cycle.
  - Pop only on the IDLE->START transition.
  - Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- FSM states: IDLE, START, GUARD, WAIT, HOLD.
  - IDLE: if the FIFO is not empty, pop; fib_n <= head; go to START. Otherwise stay.
  - START: fib_rst = 1 for exactly one cycle; timeout counter cleared; go to GUARD.
  - GUARD: one cycle in which fib_ready is ignored, masking a stale outReady from the previous job; go to WAIT.
  - WAIT:
    - If fib_ready = 1: res_data <= fib_out, res_n <= fib_n, res_err <= 0, res_valid <= 1; go to HOLD.
    - Else if counter == TIMEOUT: res_data <= 0, res_n <= fib_n, res_err <= 1, res_valid <= 1; go to HOLD.
    - Else increment the counter.
    - If fib_ready and timeout coincide, fib_ready wins (res_err = 0).
  - HOLD: res_* held stable while res_valid && !res_ready. On res_ready: res_valid <= 0; go to IDLE. The next job starts no earlier than the cycle after that.
- Latency:
  - Push to fib_rst pulse: minimum 2 cycles (1 cycle to reach IDLE-visible count, then IDLE->START).
  - fib_ready rising in WAIT to res_valid = 1: 1 cycle.
- fib_n changes only on the IDLE->START transition.
- req_ready is independent of FSM state.
- res_valid never drops without a handshake, except on rst.

Test Plan:
- Queue N = 3, 4, 5, 6 back-to-back with res_ready = 1, driving fibTopLevel -> results in order: (3, 3), (4, 11), (5, 53), (6, 309), all with res_err = 0. Exactly one single-cycle fib_rst per job; fib_n stable between pulses.
- Fill the FIFO with 4 requests while the first job is in WAIT -> req_ready = 0 at count 4. A 5th req_valid is not accepted, even in a pop cycle. All 4 results are still delivered.
- Hold res_ready = 0 for 20 cycles after N=4 completes -> res_valid, res_data = 11 and res_n = 4 stay stable; no fib_rst is issued until the cycle after res_ready = 1.
- Stub core with fib_ready tied 0, TIMEOUT = 15 -> res_valid exactly TIMEOUT+1 cycles after entering WAIT, with res_err = 1 and res_data = 0. Next job then proceeds normally.
- Stub core with fib_ready stuck 1 from the previous job -> the GUARD cycle masks it; the capture takes the new value (fib_ready asserted by stub in WAIT).
- Assert rst for 1 cycle while in WAIT with 2 requests queued -> next cycle: IDLE, count 0, res_valid = 0, fib_rst = 1 during the reset cycle. No results emitted for the discarded jobs.
